// File: rtl/ahb_decode_mux.sv
// rtl/ahb_decode_mux.sv - single-master AHB-Lite address decoder and response multiplexer
// Optional wait-state watchdog enabled by defining AHB_TIMEOUT_EN.
module ahb_decode_mux #(
    parameter int                      NUM_SLV     = 4,
    parameter logic [NUM_SLV*32-1:0]   SLV_BASE    = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0]   SLV_MASK    = {4{32'hFFFF_F000}},
    parameter int                      TIMEOUT_CYC = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             ahb_s0_haddr_i,
    input  logic                    ahb_s0_hwrite_i,
    input  logic [2:0]              ahb_s0_hsize_i,
    input  logic [2:0]              ahb_s0_hburst_i,
    input  logic [3:0]              ahb_s0_hprot_i,
    input  logic [1:0]              ahb_s0_htrans_i,
    input  logic                    ahb_s0_hmastlock_i,
    input  logic [31:0]             ahb_s0_hwdata_i,
    output logic                    ahb_s0_hready_o,
    output logic                    ahb_s0_hresp_o,
    output logic [31:0]             ahb_s0_hrdata_o,
    output logic [31:0]             ahb_m_haddr_o,
    output logic                    ahb_m_hwrite_o,
    output logic [2:0]              ahb_m_hsize_o,
    output logic [2:0]              ahb_m_hburst_o,
    output logic [3:0]              ahb_m_hprot_o,
    output logic [1:0]              ahb_m_htrans_o,
    output logic                    ahb_m_hmastlock_o,
    output logic [31:0]             ahb_m_hwdata_o,
    output logic [NUM_SLV-1:0]      ahb_m_hsel_o,
    output logic                    ahb_m_hready_o,
    input  logic [NUM_SLV-1:0]      ahb_m_hready_i,
    input  logic [NUM_SLV-1:0]      ahb_m_hresp_i,
    input  logic [NUM_SLV*32-1:0]   ahb_m_hrdata_i,
    output logic                    timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} err_state_t;

    err_state_t         state;
    logic [NUM_SLV:0]   dec;
    logic [NUM_SLV:0]   sel_q;
    logic               hit;
    logic               sel_wait;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("ahb_decode_mux: parameter out of range");
    end

    assign ahb_m_haddr_o     = ahb_s0_haddr_i;
    assign ahb_m_hwrite_o    = ahb_s0_hwrite_i;
    assign ahb_m_hsize_o     = ahb_s0_hsize_i;
    assign ahb_m_hburst_o    = ahb_s0_hburst_i;
    assign ahb_m_hprot_o     = ahb_s0_hprot_i;
    assign ahb_m_htrans_o    = ahb_s0_htrans_i;
    assign ahb_m_hmastlock_o = ahb_s0_hmastlock_i;
    assign ahb_m_hwdata_o    = ahb_s0_hwdata_i;
    assign ahb_m_hready_o    = ahb_s0_hready_o;
    assign ahb_m_hsel_o      = dec[NUM_SLV-1:0];

    // Bit NUM_SLV of dec/sel_q is the built-in default (error) slave.
    always_comb begin
        dec = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((ahb_s0_haddr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                dec[i] = 1'b1;
                hit    = 1'b1;
            end
        end
        if (!hit) dec[NUM_SLV] = 1'b1;
        if (!ahb_s0_htrans_i[1]) dec = '0;
    end

    always_comb begin
        ahb_s0_hready_o = 1'b1;
        ahb_s0_hresp_o  = 1'b0;
        ahb_s0_hrdata_o = '0;
        sel_wait        = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                ahb_s0_hready_o = ahb_m_hready_i[i];
                ahb_s0_hresp_o  = ahb_m_hresp_i[i];
                ahb_s0_hrdata_o = ahb_m_hrdata_i[i*32 +: 32];
                sel_wait        = ~ahb_m_hready_i[i];
            end
        end
        // The error pair overrides whatever slave is selected (timeout case).
        if (state == S_ERR1) begin
            ahb_s0_hready_o = 1'b0;
            ahb_s0_hresp_o  = 1'b1;
            ahb_s0_hrdata_o = '0;
        end else if (state == S_ERR2) begin
            ahb_s0_hready_o = 1'b1;
            ahb_s0_hresp_o  = 1'b1;
            ahb_s0_hrdata_o = '0;
        end
    end

`ifdef AHB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_q;
    logic        timeout_hit;

    assign timeout_hit = (state == S_IDLE) && sel_wait && (wait_cnt == 16'(TIMEOUT_CYC - 1));
    assign timeout_o   = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if ((state == S_IDLE) && sel_wait && !timeout_hit) wait_cnt <= wait_cnt + 16'd1;
            else                                               wait_cnt <= '0;
        end
    end
`else
    logic timeout_hit;

    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            sel_q <= '0;
        end else begin
            if (ahb_s0_hready_o) sel_q <= dec;
            case (state)
                S_IDLE: begin
                    if (ahb_s0_hready_o && dec[NUM_SLV]) state <= S_ERR1;
                    else if (timeout_hit)                state <= S_ERR1;
                end
                S_ERR1:  state <= S_ERR2;
                S_ERR2:  state <= dec[NUM_SLV] ? S_ERR1 : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb/tb_ahb_decode_mux.sv - directed self-checking bench for ahb_decode_mux
module tb_ahb_decode_mux;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [1:0]    htrans;
    logic          hmastlock;
    logic [31:0]   hwdata;
    logic          hready_o;
    logic          hresp_o;
    logic [31:0]   hrdata_o;
    logic [31:0]   m_haddr;
    logic          m_hwrite;
    logic [2:0]    m_hsize;
    logic [2:0]    m_hburst;
    logic [3:0]    m_hprot;
    logic [1:0]    m_htrans;
    logic          m_hmastlock;
    logic [31:0]   m_hwdata;
    logic [3:0]    m_hsel;
    logic          m_hready_o;
    logic [3:0]    slv_hready;
    logic [3:0]    slv_hresp;
    logic [127:0]  slv_hrdata;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_decode_mux #(.NUM_SLV(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite), .ahb_s0_hsize_i(hsize),
        .ahb_s0_hburst_i(hburst), .ahb_s0_hprot_i(hprot), .ahb_s0_htrans_i(htrans),
        .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
        .ahb_s0_hready_o(hready_o), .ahb_s0_hresp_o(hresp_o), .ahb_s0_hrdata_o(hrdata_o),
        .ahb_m_haddr_o(m_haddr), .ahb_m_hwrite_o(m_hwrite), .ahb_m_hsize_o(m_hsize),
        .ahb_m_hburst_o(m_hburst), .ahb_m_hprot_o(m_hprot), .ahb_m_htrans_o(m_htrans),
        .ahb_m_hmastlock_o(m_hmastlock), .ahb_m_hwdata_o(m_hwdata),
        .ahb_m_hsel_o(m_hsel), .ahb_m_hready_o(m_hready_o),
        .ahb_m_hready_i(slv_hready), .ahb_m_hresp_i(slv_hresp), .ahb_m_hrdata_i(slv_hrdata),
        .timeout_o(timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; haddr = 32'h0000_1004; htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o, timeout} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL reset_outputs: got %b/%b/%h/%b expected 1/0/00000000/0", hready_o, hresp_o, hrdata_o, timeout);
        end
        checks++;
        if (m_hsel !== 4'b0000) begin errors++; $display("FAIL reset_hsel_idle: got %b expected 0000", m_hsel); end
        htrans = 2'b10; #1;
        checks++;
        if (m_hsel !== 4'b0010) begin errors++; $display("FAIL reset_hsel_nonseq: got %b expected 0010", m_hsel); end
        checks++;
        if ({m_haddr, m_htrans} !== {32'h0000_1004, 2'b10}) begin
            errors++; $display("FAIL passthrough: got %h/%b expected 00001004/10", m_haddr, m_htrans);
        end
        htrans = 2'b00;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_slave1();
        haddr = 32'h0000_1004; htrans = 2'b10; hwrite = 1'b0;
        slv_hrdata[32 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (m_hsel !== 4'b0010) begin errors++; $display("FAIL read1_hsel: got %b expected 0010", m_hsel); end
        step();
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL read1_data: got %b/%b/%h expected 1/0/deadbeef", hready_o, hresp_o, hrdata_o);
        end
        step();
    endtask

    task automatic test_write_wait();
        haddr = 32'h0000_2010; htrans = 2'b10; hwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (m_hsel !== 4'b0100) begin errors++; $display("FAIL wr2_hsel: got %b expected 0100", m_hsel); end
        step();
        htrans = 2'b00; hwdata = 32'hCAFE_0002; slv_hready[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            // Mid-wait the master flashes an unmapped address; it must not be taken.
            if (k == 2) begin haddr = 32'h0000_8000; htrans = 2'b10; end
            else        htrans = 2'b00;
            @(negedge clk);
            checks++;
            if ({hready_o, m_hready_o, hresp_o, m_hsel} !== {1'b0, 1'b0, 1'b0, 4'b0000}) begin
                errors++; $display("FAIL wr2_wait%0d: got %b/%b/%b/%b expected 0/0/0/0000", k, hready_o, m_hready_o, hresp_o, m_hsel);
            end
            step();
        end
        htrans = 2'b00; slv_hready[2] = 1'b1;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o} !== 2'b10) begin errors++; $display("FAIL wr2_done: got %b/%b expected 1/0", hready_o, hresp_o); end
        step();
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o} !== 2'b10) begin errors++; $display("FAIL wr2_no_err: got %b/%b expected 1/0", hready_o, hresp_o); end
        step();
    endtask

    task automatic test_unmapped();
        haddr = 32'h0000_8000; htrans = 2'b10; hwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (m_hsel !== 4'b0000) begin errors++; $display("FAIL unm_hsel: got %b expected 0000", m_hsel); end
        step();
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL unm_err1: got %b/%b/%h expected 0/1/00000000", hready_o, hresp_o, hrdata_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL unm_err2: got %b/%b/%h expected 1/1/00000000", hready_o, hresp_o, hrdata_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o} !== 2'b10) begin errors++; $display("FAIL unm_idle_okay: got %b/%b expected 1/0", hready_o, hresp_o); end
        step();
    endtask

    task automatic test_back_to_back();
        slv_hrdata[0 +: 32]  = 32'h1111_0000;
        slv_hrdata[96 +: 32] = 32'h3333_0003;
        haddr = 32'h0000_0008; htrans = 2'b10;
        @(negedge clk);
        checks++;
        if (m_hsel !== 4'b0001) begin errors++; $display("FAIL b2b_hsel0: got %b expected 0001", m_hsel); end
        step();
        haddr = 32'h0000_3000; htrans = 2'b10;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o, m_hsel} !== {1'b1, 1'b0, 32'h1111_0000, 4'b1000}) begin
            errors++; $display("FAIL b2b_first: got %b/%b/%h/%b expected 1/0/11110000/1000", hready_o, hresp_o, hrdata_o, m_hsel);
        end
        step();
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h3333_0003}) begin
            errors++; $display("FAIL b2b_second: got %b/%b/%h expected 1/0/33330003", hready_o, hresp_o, hrdata_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        haddr = 32'h0000_3004; htrans = 2'b10;
        step();
        htrans = 2'b00; slv_hready[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (hready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got %b expected 0", hready_o); end
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_mid_clear: got %b/%b/%h expected 1/0/00000000", hready_o, hresp_o, hrdata_o);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({hready_o, hrdata_o} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL rst_mid_selq: got %b/%h expected 1/00000000", hready_o, hrdata_o);
        end
        slv_hready = 4'b1111;
        haddr = 32'h0000_1000; htrans = 2'b10;
        #1;
        checks++;
        if (m_hsel !== 4'b0010) begin errors++; $display("FAIL rst_mid_decode: got %b expected 0010", m_hsel); end
        step();
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL rst_mid_xfer: got %b/%b/%h expected 1/0/deadbeef", hready_o, hresp_o, hrdata_o);
        end
        step();
    endtask

    task automatic test_stall_timeout();
        logic exp_rdy, exp_rsp, exp_to;
        haddr = 32'h0000_1000; htrans = 2'b10;
        step();
        htrans = 2'b00; slv_hready[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
`ifdef AHB_TIMEOUT_EN
            exp_rdy = (k == 10);
            exp_rsp = (k >= 9);
            exp_to  = (k == 9);
`else
            exp_rdy = 1'b0;
            exp_rsp = 1'b0;
            exp_to  = 1'b0;
`endif
            @(negedge clk);
            checks++;
            if ({hready_o, hresp_o, timeout} !== {exp_rdy, exp_rsp, exp_to}) begin
                errors++; $display("FAIL stall_cyc%0d: got %b/%b/%b expected %b/%b/%b", k, hready_o, hresp_o, timeout, exp_rdy, exp_rsp, exp_to);
            end
            step();
        end
`ifndef AHB_TIMEOUT_EN
        slv_hready[1] = 1'b1;
        @(negedge clk);
        step();
`endif
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, timeout} !== 3'b100) begin
            errors++; $display("FAIL stall_after: got %b/%b/%b expected 1/0/0", hready_o, hresp_o, timeout);
        end
        haddr = 32'h0000_0004; htrans = 2'b10;
        step();
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h1111_0000}) begin
            errors++; $display("FAIL stall_next_s0: got %b/%b/%h expected 1/0/11110000", hready_o, hresp_o, hrdata_o);
        end
        step();
        slv_hready = 4'b1111;
    endtask

    initial begin
        reset = 1'b1; haddr = '0; hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000;
        hprot = 4'b0011; htrans = 2'b00; hmastlock = 1'b0; hwdata = '0;
        slv_hready = 4'b1111; slv_hresp = 4'b0000;
        slv_hrdata = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        test_reset();
        test_read_slave1();
        test_write_wait();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_stall_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
